dbus_ctrl: RTL
==============

Name: dbus_ctrl

Overview:
- Sequences every load/store of the memory stage onto the data bus.
- Registers the request and drives the bus request signals.
- Holds the bus valid signal until the response arrives, and stalls the pipeline meanwhile.
- Aligns store data and strobes, and extracts and extends load data.
- Sits between the memory stage and the data-bus port; it replaces the combinational request logic with a multi-cycle handshake controller.

Parameters:
- ADDR_W, 64, address width of the request and the bus.
- DATA_W, 64, data width. Only 64 is supported: strobe width is DATA_W/8 = 8.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- mem_valid  in  1  memory stage holds a valid load or store this cycle.
- mem_write  in  1  1 = store, 0 = load.
- mem_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword.
- mem_unsigned  in  1  load zero-extends when 1.
- mem_addr  in  ADDR_W  effective address (ALU result).
- mem_wdata  in  DATA_W  unaligned store data (rs2).
- advance  in  1  M->W pipeline register captures this cycle.
- flush  in  1  kill the instruction in the memory stage.
- dreq_valid  out  1  bus request valid.
- dreq_addr  out  ADDR_W  bus address.
- dreq_size  out  2  copy of the latched mem_size.
- dreq_strobe  out  8  byte write enables; 0 for loads.
- dreq_data  out  DATA_W  lane-aligned store data.
- dresp_addr_ok  in  1  address accepted. Informational only.
- dresp_data_ok  in  1  transaction complete.
- dresp_data  in  DATA_W  raw 64-bit read beat.
- stall  out  1  memory stage must hold.
- rdata  out  DATA_W  extended load result.
- misalign  out  1  access not naturally aligned; no bus access is made.

Behaviour:
- States: IDLE, BUSY, DONE, DRAIN. Reset (asynchronous, resetn=0) puts the block in IDLE and clears all registers.
- Outputs during and after reset: dreq_valid=0, dreq_strobe=0, dreq_addr=0, dreq_data=0, rdata=0, stall=0, misalign=0.
- Misalign check: misaligned when (size1 and addr[0]) or (size2 and addr[1:0]!=0) or (size3 and addr[2:0]!=0).
  - Combinational; asserted only in IDLE with mem_valid=1.
  - A misaligned access never leaves IDLE and stall=0.
- IDLE:
  - Outputs: dreq_valid=0. stall = mem_valid & ~misalign & ~flush.
  - If stall=1, latch the following and go to BUSY:
    - addr;
    - size;
    - unsigned;
    - strobe = (size mask 0x01/0x03/0x0F/0xFF) << addr[2:0], forced to 0 for loads;
    - data = mem_wdata << (8*addr[2:0]).
- BUSY:
  - Outputs: dreq_valid=1, fields stable from the latches, stall=1.
  - On dresp_data_ok without flush: capture the extended read into rdata (stores capture 0) and go to DONE.
  - On flush without data_ok: go to DRAIN.
  - On flush and data_ok in the same cycle: go to IDLE and discard the data.
  - The minimum load-to-use latency is 2 cycles (IDLE then BUSY with same-cycle data_ok, DONE visible in the 3rd cycle).
- Load extraction: shifted = dresp_data >> (8*addr[2:0]); take the low 8/16/32/64 bits, then sign-extend or zero-extend per the latched unsigned flag. Size 3 ignores unsigned.
- DONE:
  - Outputs: dreq_valid=0, stall=0, rdata holds the captured value.
  - On advance or flush: go to IDLE. Otherwise stay; the result is held indefinitely under a downstream stall.
  - mem_valid is ignored in DONE (no re-issue).
- DRAIN:
  - Outputs: dreq_valid=1 with unchanged fields, because a request cannot be withdrawn before data_ok. stall=1.
  - On data_ok: go to IDLE and discard the data. flush in DRAIN has no further effect.
- dreq_valid never drops between issue and data_ok. Fields never change while dreq_valid=1.
- A new request is latched no earlier than the cycle after data_ok.
- Reset mid-transaction: immediate abort, dreq_valid=0. The bus is reset by the same resetn.

Test Plan:
- Load word, addr=0x8000_0004, dresp_data=0x8765_4321_0000_0000, data_ok 3 cycles after BUSY entry -> dreq_valid high 3 cycles, stall high 4 cycles, then rdata=0xFFFF_FFFF_8765_4321 in DONE. With mem_unsigned=1 -> rdata=0x0000_0000_8765_4321.
- Store byte, addr=0x8000_0003, mem_wdata=0xAB -> dreq_strobe=0x08, dreq_data=0xAB00_0000, and dreq_valid held until data_ok. DONE is then followed by advance -> IDLE.
- Half load at addr=0x1001 -> misalign=1, stall=0, dreq_valid never asserted. A dword load at addr=0x1004 is likewise misaligned.
- Flush in the 2nd BUSY cycle, data_ok 2 cycles later -> DRAIN, dreq_valid stays 1, stall stays 1, data is discarded, return to IDLE, and rdata is unchanged.
- DONE with advance=0 for 5 cycles -> rdata stable, stall=0, no new dreq_valid. advance=1 -> IDLE; the next mem_valid issues on the following cycle.
- Assert resetn=0 mid-BUSY -> dreq_valid=0 and stall=0 without waiting for a clock edge. After release, the block is in IDLE.

Source files
------------

// File: rtl/dbus_ctrl.sv
// dbus_ctrl: multi-cycle handshake controller between the memory stage and the data bus.
// Latency: request visible on the bus the cycle after issue; result in DONE the cycle after data_ok.
// Backpressure: stall held from issue until data_ok; the request is held on the bus until data_ok.
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   mem_*                load/store from the memory stage (valid, write, size, unsigned, addr, wdata)
//   advance, flush       M->W capture this cycle / kill the memory-stage instruction
//   dreq_*               bus request: valid, addr, size, byte strobes, lane-aligned store data
//   dresp_*              bus response: addr_ok (not used), data_ok, raw read beat
//   stall                memory stage must hold
//   rdata                extended load result (0 after a store)
//   misalign             access not naturally aligned; no bus access is made
module dbus_ctrl #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64   // only 64 is supported (8 byte lanes)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_valid,
  input  logic              mem_write,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              advance,
  input  logic              flush,
  output logic              dreq_valid,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [1:0]        dreq_size,
  output logic [7:0]        dreq_strobe,
  output logic [DATA_W-1:0] dreq_data,
  input  logic              dresp_addr_ok,
  input  logic              dresp_data_ok,
  input  logic [DATA_W-1:0] dresp_data,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              misalign
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              valid_q, valid_d;
  logic              we_q, we_d;
  logic              uns_q, uns_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        strobe_q, strobe_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Address-accepted is not needed to sequence the transaction.
  logic unused_addr_ok;
  assign unused_addr_ok = dresp_addr_ok;

  // ------------------------------------------------------------------
  // Request side: alignment check, strobe and lane alignment
  // ------------------------------------------------------------------
  logic [2:0]        mem_off;
  logic              mis_raw;
  logic              in_idle;
  logic              issue;
  logic [7:0]        size_mask;
  logic [7:0]        strobe_new;
  logic [DATA_W-1:0] wdata_new;

  assign mem_off = mem_addr[2:0];
  assign in_idle = (state_q == IDLE);

  always_comb begin
    mis_raw = 1'b0;
    case (mem_size)
      2'd1:    mis_raw = mem_off[0];
      2'd2:    mis_raw = |mem_off[1:0];
      2'd3:    mis_raw = |mem_off;
      default: mis_raw = 1'b0;
    endcase
  end

  always_comb begin
    size_mask = 8'hFF;
    case (mem_size)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  end

  // Only aligned accesses are issued, so the shifted mask never spills past lane 7.
  assign strobe_new = mem_write ? (size_mask << mem_off) : 8'h00;
  assign wdata_new  = mem_wdata << {mem_off, 3'b000};

  // Issue happens straight out of IDLE; flush of the same instruction wins.
  assign issue = in_idle & mem_valid & ~mis_raw & ~flush;

  // ------------------------------------------------------------------
  // Response side: lane extraction and sign/zero extension
  // ------------------------------------------------------------------
  logic [DATA_W-1:0] rd_shifted;
  logic [DATA_W-1:0] load_ext;

  assign rd_shifted = dresp_data >> {addr_q[2:0], 3'b000};

  always_comb begin
    load_ext = rd_shifted;
    case (size_q)
      2'd0:    load_ext = {{(DATA_W-8){~uns_q & rd_shifted[7]}}, rd_shifted[7:0]};
      2'd1:    load_ext = {{(DATA_W-16){~uns_q & rd_shifted[15]}}, rd_shifted[15:0]};
      2'd2:    load_ext = {{(DATA_W-32){~uns_q & rd_shifted[31]}}, rd_shifted[31:0]};
      default: load_ext = rd_shifted;
    endcase
  end

  // ------------------------------------------------------------------
  // Next state
  // ------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    we_d     = we_q;
    uns_d    = uns_q;
    size_d   = size_q;
    addr_d   = addr_q;
    strobe_d = strobe_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;

    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d  = BUSY;
          valid_d  = 1'b1;
          we_d     = mem_write;
          uns_d    = mem_unsigned;
          size_d   = mem_size;
          addr_d   = mem_addr;
          strobe_d = strobe_new;
          wdata_d  = wdata_new;
        end
      end

      BUSY: begin
        if (dresp_data_ok && flush) begin
          // Killed in the completing cycle: nothing left to wait for, drop the data.
          state_d = IDLE;
          valid_d = 1'b0;
        end else if (dresp_data_ok) begin
          state_d = DONE;
          valid_d = 1'b0;
          rdata_d = we_q ? '0 : load_ext;
        end else if (flush) begin
          // The bus cannot retract a request; keep it up until data_ok.
          state_d = DRAIN;
        end
      end

      DONE: begin
        // Result held for the pipeline; mem_valid is not looked at here.
        if (advance || flush) begin
          state_d = IDLE;
        end
      end

      DRAIN: begin
        if (dresp_data_ok) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      size_q   <= 2'd0;
      addr_q   <= '0;
      strobe_q <= 8'h00;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      we_q     <= we_d;
      uns_q    <= uns_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      strobe_q <= strobe_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign dreq_valid  = valid_q;
  assign dreq_addr   = addr_q;
  assign dreq_size   = size_q;
  assign dreq_strobe = strobe_q;
  assign dreq_data   = wdata_q;
  assign rdata       = rdata_q;

  // The IDLE terms are combinational from the memory stage, so they are gated
  // with resetn to keep both low for the whole reset window.
  assign misalign = resetn & in_idle & mem_valid & mis_raw;
  assign stall    = resetn & (issue | (state_q == BUSY) | (state_q == DRAIN));

endmodule
